// File: rtl/obc_da_dot_engine.sv
// Bit-serial offset-binary-coded distributed-arithmetic dot-product engine.
// Computes y = sum_n c[n]*x[n]. Sample bits are streamed MSB-first: one
// OBC partial sum T over all input pairs per cycle, then a shift-accumulate.
// The loadable coefficient sum C removes the OBC offset at the end.
module obc_da_dot_engine #(
  parameter int N_TAPS = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  localparam int OUT_W = DATA_W + COEF_W + $clog2(N_TAPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       coef_we,
  input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]          coef_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_TAPS*DATA_W-1:0]   x_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           y_out
);

  localparam int ACC_W   = OUT_W + 1;
  localparam int EXT_W   = ACC_W - COEF_W;
  localparam int N_PAIRS = N_TAPS / 2;
  localparam int CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MSB = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_HOLD} state_t;

  state_t                           state_q, state_d;
  logic                             started_q;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic signed [ACC_W-1:0]          acc_q, acc_d;
  logic [OUT_W-1:0]                 y_q, y_d;
  logic                             ov_q, ov_d;
  logic [N_TAPS-1:0][DATA_W-1:0]    x_q, x_shift;
  logic                             x_load, x_shift_en;

  logic signed [COEF_W-1:0]         coef_q [N_TAPS];
  logic signed [ACC_W-1:0]          csum_q, csum_d;
  logic                             coef_wr;

  logic signed [ACC_W-1:0]          psum [N_PAIRS+1];
  logic signed [ACC_W-1:0]          t_sum;
  logic signed [ACC_W-1:0]          diff;

  function automatic logic signed [ACC_W-1:0] sext_coef(input logic [COEF_W-1:0] v);
    return {{EXT_W{v[COEF_W-1]}}, v};
  endfunction

  // Coefficients may only change while no vector is in flight.
  assign coef_wr = coef_we && (state_q == S_IDLE);
  assign csum_d  = csum_q - sext_coef(coef_q[coef_addr]) + sext_coef(coef_data);

  // Coefficient store and running coefficient sum C.
  // NOTE: the coefficient array is reset explicitly because a cleared set is
  // part of the reset contract; the sample register below is always loaded
  // before use, so it carries no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q <= '{default: '0};
      csum_q <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_data;
      csum_q            <= csum_d;
    end
  end

  // One OBC pair term per input pair, chained into the per-cycle sum T.
  assign psum[0] = '0;
  for (genvar k = 0; k < N_PAIRS; k++) begin : g_pair
    logic                    b_lo, b_hi;
    logic signed [ACC_W-1:0] c_lo, c_hi, pair;
    assign b_lo = x_q[2*k][DATA_W-1];
    assign b_hi = x_q[2*k+1][DATA_W-1];
    assign c_lo = sext_coef(coef_q[2*k]);
    assign c_hi = sext_coef(coef_q[2*k+1]);
    assign pair = c_lo + ((b_lo == b_hi) ? c_hi : -c_hi);
    assign psum[k+1] = psum[k] + (b_lo ? pair : -pair);
  end
  assign t_sum = psum[N_PAIRS];

  // Each sample shifts left so the bit under evaluation always sits at the MSB.
  for (genvar n = 0; n < N_TAPS; n++) begin : g_shift
    assign x_shift[n] = {x_q[n][DATA_W-2:0], 1'b0};
  end

  // Remove the OBC offset; the difference is always even, so the shift is exact.
  assign diff = acc_q - csum_q;

  // Next-state and datapath control for the IDLE/RUN/FINAL/HOLD sequence.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    y_d        = y_q;
    ov_d       = ov_q;
    x_load     = 1'b0;
    x_shift_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          x_load  = 1'b1;
          acc_d   = '0;
          cnt_d   = CNT_MSB;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d      = {acc_q[ACC_W-2:0], 1'b0} + ((cnt_q == CNT_MSB) ? -t_sum : t_sum);
        x_shift_en = 1'b1;
        cnt_d      = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FINAL;
      end
      S_FINAL: begin
        y_d     = diff[ACC_W-1:1];
        ov_d    = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers; reset aborts any vector in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      started_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      ov_q      <= ov_d;
    end
  end

  // Sample register: captured on accept, shifted one bit per RUN cycle.
  always_ff @(posedge clk) begin
    if (x_load) begin
      x_q <= x_in;
    end else if (x_shift_en) begin
      x_q <= x_shift;
    end
  end

  // in_ready stays low until the first edge after reset release.
  assign in_ready  = started_q && (state_q == S_IDLE);
  assign out_valid = ov_q;
  assign y_out     = y_q;

endmodule

// File: tb/tb_obc_da_dot_engine.sv
// Testbench for obc_da_dot_engine: a transaction-level reference model
// (plain dot product plus accept/latency/handshake bookkeeping) compared
// against the DUT every cycle, plus directed vectors with literal results.
module tb_obc_da_dot_engine;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 4;
  localparam int OW = DW + CW + AW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              coef_we = 1'b0;
  logic [AW-1:0]     coef_addr = '0;
  logic [CW-1:0]     coef_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*DW-1:0]   x_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OW-1:0]     y_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  obc_da_dot_engine #(.N_TAPS(N), .DATA_W(DW), .COEF_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out)
  );

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_c [N] = '{default: 0};
  bit     m_ready = 1'b0;
  bit     m_valid = 1'b0;
  bit     m_busy  = 1'b0;
  longint m_y     = 0;
  longint m_pend  = 0;
  int     m_cnt   = 0;

  function automatic longint sample(input logic [N*DW-1:0] v, input int n);
    logic signed [DW-1:0] s;
    s = v[n*DW +: DW];
    return longint'(s);
  endfunction

  function automatic longint dot(input logic [N*DW-1:0] v);
    longint acc;
    acc = 0;
    for (int n = 0; n < N; n++) acc += m_c[n] * sample(v, n);
    return acc;
  endfunction

  task automatic model_step();
    logic signed [CW-1:0] cd;
    if (!rst_n) begin
      foreach (m_c[n]) m_c[n] = 0;
      m_ready = 1'b0; m_valid = 1'b0; m_busy = 1'b0;
      m_y = 0; m_pend = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (m_ready) begin
        if (coef_we) begin
          cd = coef_data;
          m_c[coef_addr] = longint'(cd);
        end
        if (in_valid) begin
          m_pend  = dot(x_in);
          m_busy  = 1'b1;
          m_cnt   = 0;
          m_ready = 1'b0;
        end
      end else begin
        m_ready = 1'b1;
      end
    end else if (!m_valid) begin
      m_cnt++;
      if (m_cnt == DW + 1) begin
        m_valid = 1'b1;
        m_y     = m_pend;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_ready = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- per-cycle comparison ----------------
  bit cmp_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("cyc in_ready", in_ready, m_ready);
      check("cyc out_valid", out_valid, m_valid);
      check("cyc y_out", $signed(y_out), m_y);
    end
  end

  // Random backpressure generator.
  bit rand_or = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rand_or) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [N*DW-1:0] fill_const(input logic [DW-1:0] v);
    logic [N*DW-1:0] r;
    for (int n = 0; n < N; n++) r[n*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [N*DW-1:0] fill_idx(input int off);
    logic [N*DW-1:0] r;
    for (int n = 0; n < N; n++) r[n*DW +: DW] = DW'(n + off);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] rand_x();
    logic [N*DW-1:0] r;
    for (int n = 0; n < N; n++) r[n*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check({name, " ready timeout"}, in_ready, 1);
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [CW-1:0] d);
    wait_ready("coef write");
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Sends one vector; checks latency and optionally a literal result.
  // mid_wr issues a coefficient write two cycles into the computation.
  task automatic run_vec(input logic [N*DW-1:0] x, input string name,
                         input bit lit_en, input longint lit,
                         input bit mid_wr, input logic [AW-1:0] wa,
                         input logic [CW-1:0] wd);
    int lat;
    wait_ready(name);
    in_valid = 1'b1;
    x_in     = x;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = rand_x();
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (mid_wr && lat == 2) begin
        coef_we = 1'b1; coef_addr = wa; coef_data = wd;
      end
      if (mid_wr && lat == 3) coef_we = 1'b0;
      if (out_valid) break;
    end
    check({name, " latency"}, lat, 17);
    if (lit_en) check({name, " y"}, $signed(y_out), lit);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset y_out", $signed(y_out), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready after release", in_ready, 1);

    // All-ones coefficients and samples.
    for (int n = 0; n < N; n++) write_coef(AW'(n), CW'(1));
    run_vec(fill_const(16'd1), "ones", 1, 16, 0, '0, '0);

    // c[n]=n with x=-1, then x[n]=n-8.
    for (int n = 0; n < N; n++) write_coef(AW'(n), CW'(n));
    run_vec(fill_const(16'hFFFF), "neg ones", 1, -120, 0, '0, '0);
    run_vec(fill_idx(-8), "ramp", 1, 280, 0, '0, '0);

    // Most negative coefficients and samples: y = 2^34.
    for (int n = 0; n < N; n++) write_coef(AW'(n), 16'h8000);
    run_vec(fill_const(16'h8000), "min x min", 1, 64'sd17179869184, 0, '0, '0);

    // Output backpressure: result held, new vectors refused.
    for (int n = 0; n < N; n++) write_coef(AW'(n), CW'(n));
    wait_ready("hold");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x_in      = fill_const(16'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check("hold latency", lat, 17);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = fill_const(16'd2);
      check("hold out_valid", out_valid, 1);
      check("hold y", $signed(y_out), 120);
      check("hold in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release out_valid", out_valid, 0);
    check("release in_ready", in_ready, 1);

    // Coefficient write during a computation is ignored; in IDLE it lands.
    run_vec(fill_const(16'd1), "write in run", 1, 120, 1, AW'(3), CW'(1000));
    write_coef(AW'(3), CW'(1000));
    run_vec(fill_const(16'd1), "write in idle", 1, 1117, 0, '0, '0);

    // Reset in the middle of a computation.
    wait_ready("abort");
    in_valid = 1'b1;
    x_in     = fill_idx(0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort y_out", $signed(y_out), 0);
    check("abort in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_vec(rand_x(), "after abort", 1, 0, 0, '0, '0);

    // Randomised coefficients, samples and backpressure.
    rand_or = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int nw;
      logic [N*DW-1:0] xv;
      nw = (it == 0) ? N : $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        case ($urandom_range(0, 5))
          0:       write_coef(AW'($urandom), 16'h8000);
          1:       write_coef(AW'($urandom), 16'h7FFF);
          default: write_coef(AW'($urandom), CW'($urandom));
        endcase
      end
      case ($urandom_range(0, 7))
        0:       xv = fill_const(16'h8000);
        1:       xv = fill_const(16'h7FFF);
        default: xv = rand_x();
      endcase
      run_vec(xv, "random", 0, 0, 0, '0, '0);
    end
    rand_or = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_ready("drain");
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
